// File: rtl/deser8_way_pkg.sv
// deser8_way_pkg: shared widths, output FSM encoding and bit-position helper
package deser8_way_pkg;
    localparam int DESER_W = 8;
    localparam int CNT_W = 3;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] pos, input bit lsb_first);
        return lsb_first ? pos : CNT_W'(DESER_W - 1) - pos;
    endfunction
endpackage

// File: rtl/deser8_way_if.sv
// deser8_way_if: serial input and byte output handshakes of the deserializer
interface deser8_way_if;
    import deser8_way_pkg::*;
    logic in_valid, in_bit, in_sof, in_ready;
    logic out_valid, out_ready, out_any, sync_err;
    logic [DESER_W-1:0] out;
    modport master (
        output in_valid, in_bit, in_sof, out_ready,
        input in_ready, out_valid, out, out_any, sync_err
    );
    modport slave (
        input in_valid, in_bit, in_sof, out_ready,
        output in_ready, out_valid, out, out_any, sync_err
    );
endinterface

// File: rtl/deser8_way_or8_reduce.sv
// or8_reduce: 8-way OR built as a three-level tree of 2-input ORs
module or8_reduce (
    input logic [7:0] d,
    output logic y
);
    logic [3:0] l1;
    logic [1:0] l2;
    assign l1 = d[7:4] | d[3:0];
    assign l2 = l1[3:2] | l1[1:0];
    assign y = l2[1] | l2[0];
endmodule

// File: rtl/deser8_way.sv
// deser8_way: bit-serial to byte deserializer with one-entry output holding register
module deser8_way
    import deser8_way_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst_n,
    deser8_way_if.slave bus
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] count, pos;
    logic [DESER_W-1:0] shreg, shreg_nxt, out_q;
    logic sync_err_q, in_fire, last, done, any;

    assign last = count == CNT_W'(DESER_W - 1);
    assign bus.in_ready = !(last && state == FULL && !bus.out_ready);
    assign in_fire = bus.in_valid && bus.in_ready;
    // an sof bit at the last position restarts the frame, so it never completes a byte
    assign done = in_fire && !bus.in_sof && last;
    assign pos = bit_pos(bus.in_sof ? '0 : count, LSB_FIRST);

    always_comb begin
        shreg_nxt = bus.in_sof ? '0 : shreg;
        shreg_nxt[pos] = bus.in_bit;
    end

    always_comb begin
        state_nxt = done ? FULL : (bus.out_ready ? EMPTY : state);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            count <= '0;
            shreg <= '0;
            out_q <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sync_err_q <= in_fire && bus.in_sof && count != '0;
            if (in_fire) begin
                count <= bus.in_sof ? CNT_W'(1) : count + 1'b1;
                shreg <= done ? '0 : shreg_nxt;
            end
            if (done) out_q <= shreg_nxt;
        end
    end

    or8_reduce u_or8 (.d(out_q), .y(any));

    assign bus.out = out_q;
    assign bus.out_valid = state == FULL;
    assign bus.out_any = any && state == FULL;
    assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_deser8_way.sv
// tb_deser8_way: random and directed checks of both bit orders against a frame-queue model
module tb_deser8_way;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deser8_way_if i0 ();
    deser8_way_if i1 ();
    deser8_way #(.LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    deser8_way #(.LSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

    int errors = 0;
    int checks = 0;
    int hs = 0;
    bit frame[$];
    bit exp_valid = 1'b0;
    bit exp_err = 1'b0;
    logic [7:0] exp0 = 8'h00;
    logic [7:0] exp1 = 8'h00;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit sof, input bit rdy);
        i0.in_valid = v; i0.in_bit = b; i0.in_sof = sof; i0.out_ready = rdy;
        i1.in_valid = v; i1.in_bit = b; i1.in_sof = sof; i1.out_ready = rdy;
    endtask

    task automatic check_out();
        check("out_valid0", i0.out_valid, exp_valid);
        check("out_valid1", i1.out_valid, exp_valid);
        if (exp_valid) begin
            check("out0", i0.out, exp0);
            check("out1", i1.out, exp1);
        end
        check("out_any0", i0.out_any, exp_valid && exp0 != 8'h00);
        check("out_any1", i1.out_any, exp_valid && exp1 != 8'h00);
        check("sync_err0", i0.sync_err, exp_err);
        check("sync_err1", i1.sync_err, exp_err);
    endtask

    task automatic step(input bit v, input bit b, input bit sof, input bit rdy);
        bit ready, fire, made;
        logic [7:0] b0, b1;
        @(negedge clk);
        drive(v, b, sof, rdy);
        #1;
        ready = !(frame.size() == 7 && exp_valid && !rdy);
        check("in_ready0", i0.in_ready, ready);
        check("in_ready1", i1.in_ready, ready);
        if (i0.out_valid && rdy) hs++;
        fire = v && ready;
        made = 1'b0;
        b0 = 8'h00;
        b1 = 8'h00;
        @(posedge clk);
        exp_err = fire && sof && frame.size() != 0;
        if (fire) begin
            if (sof) frame.delete();
            frame.push_back(b);
            if (frame.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    b0[k] = frame[k];
                    b1[7-k] = frame[k];
                end
                frame.delete();
                made = 1'b1;
            end
        end
        if (made) begin
            exp_valid = 1'b1;
            exp0 = b0;
            exp1 = b1;
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        #1;
        check_out();
    endtask

    task automatic send_byte(input logic [7:0] val, input bit rdy);
        for (int k = 0; k < 8; k++) step(1'b1, val[k], 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        frame.delete();
        exp_valid = 1'b0;
        exp_err = 1'b0;
        exp0 = 8'h00;
        exp1 = 8'h00;
        #1;
        check_out();
        check("rst_out0", i0.out, 8'h00);
        check("rst_out1", i1.out, 8'h00);
        check("rst_in_ready", i0.in_ready, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();

        pat = 8'h85;
        send_byte(pat, 1'b1);
        check("first_lsb", i0.out, 8'h85);
        check("first_msb", i1.out, 8'hA1);
        check("first_any", i0.out_any, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("first_drop", i0.out_valid, 8'h00);

        send_byte(8'h00, 1'b1);
        check("zero_valid", i0.out_valid, 8'h01);
        check("zero_any", i0.out_any, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        pat = 8'h5A;
        send_byte(8'h3C, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, pat[k], 1'b0, 1'b0);
        check("hold_out", i0.out, 8'h3C);
        step(1'b1, pat[7], 1'b0, 1'b0);
        check("stall_ready", i0.in_ready, 8'h00);
        check("stall_out", i0.out, 8'h3C);
        step(1'b1, pat[7], 1'b0, 1'b1);
        check("replace_out", i0.out, 8'h5A);
        check("replace_valid", i0.out_valid, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("resync_pulse", i0.sync_err, 8'h01);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("resync_ff", i0.out, 8'hFF);
        check("resync_pulse_end", i0.sync_err, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("sof_at_zero", i0.sync_err, 8'h00);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sof_at_zero_byte", i0.out, 8'hFE);

        send_byte(8'hC3, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_byte(8'h96, 1'b1);
        check("post_rst_lsb", i0.out, 8'h96);
        check("post_rst_msb", i1.out, 8'h69);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        hs = 0;
        for (int k = 0; k < 64; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("throughput_bytes", 8'(hs), 8'd8);

        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/deser8_way.md
Name: deser8_way

Overview:
- Bit-serial to 8-bit deserializer: the fan-out counterpart of the 8-way OR reduction.
- Accepts one bit per handshake and assembles 8 bits into a byte.
- Presents the byte on a valid/ready output with a one-entry holding register.
- `out_any` gives the 8-way OR of the presented byte for downstream zero-detect.

Parameters:
- `LSB_FIRST`, default 1: 1 = first accepted bit lands in `out[0]`; 0 = first accepted bit lands in `out[7]`.

Ports:
- `clk`  input  1  the single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_bit`  input  1  serial data bit.
- `in_sof`  input  1  qualified by `in_valid`; this bit is bit 0 of a new byte.
- `in_ready`  output  1  deserializer accepts a bit this cycle.
- `out_valid`  output  1  `out` holds a complete byte.
- `out_ready`  input  1  consumer takes the byte this cycle.
- `out`  output  8  assembled byte.
- `out_any`  output  1  OR of `out[7:0]`; qualified by `out_valid`, 0 when `out_valid`=0.
- `sync_err`  output  1  one-cycle pulse: a partial byte was discarded by `in_sof`.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - `rst_n`=0 at a rising edge sets: bit count=0, shift reg=0, `out`=8'h00, `out_valid`=0, `sync_err`=0.
  - `in_ready` is 1 out of reset.
- Mid-operation reset: the partial byte and the held byte are both discarded; no `sync_err`.
- Input accept: `in_fire` = `in_valid` & `in_ready`.
  - On `in_fire`, the bit is written to shift position `count`, counting in accept order.
  - Position mapping is LSB_FIRST: position `count`; else position 7-`count`.
  - `count` increments modulo 8.
- Output register FSM, two states:
  - EMPTY (`out_valid`=0) -> FULL when the 8th bit is accepted (`count`=7 and `in_fire`).
  - FULL (`out_valid`=1) -> EMPTY when `out_ready`=1 and no 8th bit is accepted that cycle.
  - FULL stays FULL when `out_ready`=1 and an 8th bit is accepted in the same cycle. The new byte replaces the old one with no bubble; `out_valid` stays 1.
- Latency: `out`/`out_valid` update on the edge that accepts the 8th bit, so the byte is visible the cycle after the 8th `in_fire`.
- Back-pressure:
  - `in_ready` = !(`count`==7 & `out_valid` & !`out_ready`).
  - Bits 0..6 of the next byte are always accepted while a byte is held.
  - `in_ready` is combinational from `out_ready` only; there is no path from `in_valid`.
- `out` is stable while `out_valid`=1 and `out_ready`=0.
- Frame sync (`in_fire` with `in_sof`=1):
  - The bit is written as position 0 and `count` becomes 1.
  - Previously collected bits are discarded: the shift reg is cleared except the new bit.
  - If the old `count` != 0, `sync_err` pulses for exactly the next cycle.
  - If the old `count` == 0, no error.
  - `in_sof` is ignored when `in_fire`=0.
- `in_sof` at `count`=7: the partial byte is dropped and no byte is emitted. `in_ready` follows the same rule regardless of `in_sof`.
- Wrap-around: after the 8th bit `count` returns to 0; the next bit starts a new byte without `in_sof`.
- `out_any` is combinational from the `out` register AND `out_valid`; it needs no extra register.

Decomposition:
- Shared package constants:
  - `DESER_W` = 8.
  - `CNT_W` = 3.
  - Output FSM state encoding: EMPTY=1'b0, FULL=1'b1.
- One natural sub-module: `or8_reduce`, the combinational 8-way OR used for `out_any`. It is a gate tree built from 2-input ORs.
- Shift/count/FSM logic stays in `deser8_way`.

Test Plan:
- Reset, LSB_FIRST=1:
  - Stimulus: drive bits 1,0,1,0,0,0,0,1 with `in_valid`=1 every cycle, `out_ready`=1.
  - Required: `out_valid`=1 for one cycle the cycle after the 8th bit, `out`=8'h85, `out_any`=1.
  - Repeat with LSB_FIRST=0: `out`=8'hA1.
- Zero byte:
  - Stimulus: eight 0 bits.
  - Required: `out`=8'h00, `out_valid`=1, `out_any`=0; while `out_valid`=0, `out_any`=0.
- Back-pressure:
  - Stimulus: `out_ready`=0; send byte 8'h3C, then 7 bits of the next byte.
  - Required: `in_ready` stays 1 for those 7 bits and drops to 0 at `count`=7; `out` stays 8'h3C.
  - Stimulus: raise `out_ready`.
  - Required: the 8th bit is accepted that cycle, the next byte replaces 8'h3C, and `out_valid` never drops.
- Resync:
  - Stimulus: send 3 bits, then a bit with `in_sof`=1, then 7 more bits, all 1s.
  - Required: `sync_err` is a single-cycle pulse after the `in_sof` bit; the byte emitted is 8'hFF from the `in_sof` bit onward; no byte from the first 3 bits.
  - Stimulus: `in_sof` at `count`=0.
  - Required: no `sync_err`.
- Reset mid-byte:
  - Stimulus: 5 bits in, plus a held byte with `out_valid`=1, then `rst_n`=0 for one cycle.
  - Required: `out_valid`=0, `out`=8'h00, `sync_err`=0; the next 8 bits form a clean byte.
- Throughput:
  - Stimulus: 64 random bits at `in_valid`=1, `out_ready`=1.
  - Required: exactly 8 bytes, matching the scoreboard; `in_ready`=1 throughout.
